inorder_rs_entry_array: RTL and testbench

- Entry storage for the in-order store/issue reservation station; it sits directly beside the in-order alloc/issue pointer unit.
- It accepts up to two dispatched instructions per cycle at alloc_ptr_i and alloc_ptr_i+1, and captures operands from two writeback buses.
- It produces busy_vector_o, busy_vector_next_o and ready_vector_o for the pointer unit.
- It presents the entry at issue_ptr_i to the execute stage and frees it on issue.

---
 rtl/inorder_rs_entry_array.sv | 156 +++++++++++++++
 tb/tb_inorder_rs_entry_array.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inorder_rs_entry_array.sv
// Entry storage for the in-order store/issue reservation station: dual dispatch, two-bus wakeup, indexed issue read.
// Optional macro RS_WAKEUP_FORWARD_EN: same-cycle writeback data feeds readiness and issue operands.
module inorder_rs_entry_array #(
    parameter int ENT_SEL   = 2,
    parameter int ENT_NUM   = 4,
    parameter int DATA_LEN  = 32,
    parameter int RRF_SEL   = 6,
    parameter int PAYLOAD_W = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [ENT_SEL-1:0]   alloc_ptr_i,
    input  logic                 we_1_i,
    input  logic                 we_2_i,
    input  logic [PAYLOAD_W-1:0] payload_1_i,
    input  logic [PAYLOAD_W-1:0] payload_2_i,
    input  logic [RRF_SEL-1:0]   rrftag_1_i,
    input  logic [RRF_SEL-1:0]   rrftag_2_i,
    input  logic [DATA_LEN-1:0]  src1_1_i,
    input  logic [DATA_LEN-1:0]  src2_1_i,
    input  logic [DATA_LEN-1:0]  src1_2_i,
    input  logic [DATA_LEN-1:0]  src2_2_i,
    input  logic                 src1_valid_1_i,
    input  logic                 src2_valid_1_i,
    input  logic                 src1_valid_2_i,
    input  logic                 src2_valid_2_i,
    input  logic                 wb_valid_0_i,
    input  logic                 wb_valid_1_i,
    input  logic [RRF_SEL-1:0]   wb_tag_0_i,
    input  logic [RRF_SEL-1:0]   wb_tag_1_i,
    input  logic [DATA_LEN-1:0]  wb_data_0_i,
    input  logic [DATA_LEN-1:0]  wb_data_1_i,
    input  logic [ENT_SEL-1:0]   issue_ptr_i,
    input  logic                 issue_i,
    input  logic                 kill_i,
    output logic [ENT_NUM-1:0]   busy_vector_o,
    output logic [ENT_NUM-1:0]   busy_vector_next_o,
    output logic [ENT_NUM-1:0]   ready_vector_o,
    output logic [PAYLOAD_W-1:0] issue_payload_o,
    output logic [RRF_SEL-1:0]   issue_rrftag_o,
    output logic [DATA_LEN-1:0]  issue_src1_o,
    output logic [DATA_LEN-1:0]  issue_src2_o
);

    typedef struct packed {
        logic                valid;
        logic [DATA_LEN-1:0] data;
    } opnd_t;

    // An invalid operand carries its producer tag in the low bits; bus 0 wins a double match.
    function automatic opnd_t resolve(input logic valid, input logic [DATA_LEN-1:0] data);
        opnd_t r;
        r.valid = valid;
        r.data  = data;
        if (!valid) begin
            if (wb_valid_0_i && (wb_tag_0_i == data[RRF_SEL-1:0])) begin
                r.valid = 1'b1;
                r.data  = wb_data_0_i;
            end else if (wb_valid_1_i && (wb_tag_1_i == data[RRF_SEL-1:0])) begin
                r.valid = 1'b1;
                r.data  = wb_data_1_i;
            end
        end
        return r;
    endfunction

    logic [ENT_NUM-1:0]   busy;
    logic [PAYLOAD_W-1:0] payload [ENT_NUM];
    logic [RRF_SEL-1:0]   rrftag  [ENT_NUM];
    opnd_t                src1    [ENT_NUM];
    opnd_t                src2    [ENT_NUM];

    opnd_t                src1_eff [ENT_NUM];
    opnd_t                src2_eff [ENT_NUM];
    opnd_t                d1_src1, d1_src2, d2_src1, d2_src2;
    logic [ENT_SEL-1:0]   alloc_ptr_2;
    logic [ENT_NUM-1:0]   wr_1, wr_2, issue_oh;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        alloc_ptr_2 = alloc_ptr_i + ENT_SEL'(1);
        wr_1        = '0;
        wr_2        = '0;
        issue_oh    = '0;
        if (we_1_i)  wr_1[alloc_ptr_i] = 1'b1;
        if (we_2_i)  wr_2[alloc_ptr_2] = 1'b1;
        if (issue_i) issue_oh[issue_ptr_i] = 1'b1;

        d1_src1 = resolve(src1_valid_1_i, src1_1_i);
        d1_src2 = resolve(src2_valid_1_i, src2_1_i);
        d2_src1 = resolve(src1_valid_2_i, src1_2_i);
        d2_src2 = resolve(src2_valid_2_i, src2_2_i);

        for (int i = 0; i < ENT_NUM; i++) begin
            src1_eff[i] = resolve(src1[i].valid, src1[i].data);
            src2_eff[i] = resolve(src2[i].valid, src2[i].data);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // NOTE: the data arrays are cleared along with busy because reset must leave every field at zero.
            busy <= '0;
            for (int i = 0; i < ENT_NUM; i++) begin
                payload[i] <= '0;
                rrftag[i]  <= '0;
                src1[i]    <= '0;
                src2[i]    <= '0;
            end
        end else begin
            // NOTE: all state uses non-blocking assignment so every entry sees the pre-edge values.
            for (int i = 0; i < ENT_NUM; i++) begin
                if (kill_i) begin
                    busy[i] <= 1'b0;
                end else if (wr_1[i] || wr_2[i]) begin
                    busy[i]    <= 1'b1;
                    payload[i] <= wr_1[i] ? payload_1_i : payload_2_i;
                    rrftag[i]  <= wr_1[i] ? rrftag_1_i  : rrftag_2_i;
                    src1[i]    <= wr_1[i] ? d1_src1     : d2_src1;
                    src2[i]    <= wr_1[i] ? d1_src2     : d2_src2;
                end else if (busy[i]) begin
                    if (issue_oh[i]) begin
                        busy[i] <= 1'b0;
                    end else begin
                        src1[i] <= src1_eff[i];
                        src2[i] <= src2_eff[i];
                    end
                end
            end
        end
    end

    assign busy_vector_o      = busy;
    assign busy_vector_next_o = busy & ~issue_oh;
    assign issue_payload_o    = payload[issue_ptr_i];
    assign issue_rrftag_o     = rrftag[issue_ptr_i];

`ifdef RS_WAKEUP_FORWARD_EN
    always_comb begin
        for (int i = 0; i < ENT_NUM; i++) begin
            ready_vector_o[i] = busy[i] & src1_eff[i].valid & src2_eff[i].valid;
        end
    end
    assign issue_src1_o = src1_eff[issue_ptr_i].data;
    assign issue_src2_o = src2_eff[issue_ptr_i].data;
`else
    always_comb begin
        for (int i = 0; i < ENT_NUM; i++) begin
            ready_vector_o[i] = busy[i] & src1[i].valid & src2[i].valid;
        end
    end
    assign issue_src1_o = src1[issue_ptr_i].data;
    assign issue_src2_o = src2[issue_ptr_i].data;
`endif

endmodule

// File: tb/tb_inorder_rs_entry_array.sv
// Self-checking bench for inorder_rs_entry_array: entry-level model compared every cycle plus directed literal checks.
// Honours RS_WAKEUP_FORWARD_EN in both the model and the literal expectations.
module tb_inorder_rs_entry_array;

    localparam int ES = 2;
    localparam int EN = 4;
    localparam int DL = 32;
    localparam int RS = 6;
    localparam int PW = 16;
`ifdef RS_WAKEUP_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [ES-1:0] alloc_ptr_i;
    logic          we_1_i, we_2_i;
    logic [PW-1:0] payload_1_i, payload_2_i;
    logic [RS-1:0] rrftag_1_i, rrftag_2_i;
    logic [DL-1:0] src1_1_i, src2_1_i, src1_2_i, src2_2_i;
    logic          src1_valid_1_i, src2_valid_1_i, src1_valid_2_i, src2_valid_2_i;
    logic          wb_valid_0_i, wb_valid_1_i;
    logic [RS-1:0] wb_tag_0_i, wb_tag_1_i;
    logic [DL-1:0] wb_data_0_i, wb_data_1_i;
    logic [ES-1:0] issue_ptr_i;
    logic          issue_i, kill_i;
    logic [EN-1:0] busy_vector_o, busy_vector_next_o, ready_vector_o;
    logic [PW-1:0] issue_payload_o;
    logic [RS-1:0] issue_rrftag_o;
    logic [DL-1:0] issue_src1_o, issue_src2_o;

    inorder_rs_entry_array #(
        .ENT_SEL(ES), .ENT_NUM(EN), .DATA_LEN(DL), .RRF_SEL(RS), .PAYLOAD_W(PW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .alloc_ptr_i(alloc_ptr_i),
        .we_1_i(we_1_i), .we_2_i(we_2_i),
        .payload_1_i(payload_1_i), .payload_2_i(payload_2_i),
        .rrftag_1_i(rrftag_1_i), .rrftag_2_i(rrftag_2_i),
        .src1_1_i(src1_1_i), .src2_1_i(src2_1_i), .src1_2_i(src1_2_i), .src2_2_i(src2_2_i),
        .src1_valid_1_i(src1_valid_1_i), .src2_valid_1_i(src2_valid_1_i),
        .src1_valid_2_i(src1_valid_2_i), .src2_valid_2_i(src2_valid_2_i),
        .wb_valid_0_i(wb_valid_0_i), .wb_valid_1_i(wb_valid_1_i),
        .wb_tag_0_i(wb_tag_0_i), .wb_tag_1_i(wb_tag_1_i),
        .wb_data_0_i(wb_data_0_i), .wb_data_1_i(wb_data_1_i),
        .issue_ptr_i(issue_ptr_i), .issue_i(issue_i), .kill_i(kill_i),
        .busy_vector_o(busy_vector_o), .busy_vector_next_o(busy_vector_next_o),
        .ready_vector_o(ready_vector_o), .issue_payload_o(issue_payload_o),
        .issue_rrftag_o(issue_rrftag_o), .issue_src1_o(issue_src1_o), .issue_src2_o(issue_src2_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: one record per entry ----------------
    typedef struct packed {
        logic               busy;
        logic [PW-1:0]      pl;
        logic [RS-1:0]      dst;
        logic [1:0][DL-1:0] op;
        logic [1:0]         rdy;
    } ent_t;

    ent_t m [EN];
    bit   model_ok = 1'b0;

    // First valid writeback bus (lowest index) carrying this tag, as {hit, data}.
    function automatic logic [DL:0] snoop(input logic [RS-1:0] tag);
        logic [1:0]         v;
        logic [1:0][RS-1:0] t;
        logic [1:0][DL-1:0] d;
        v = {wb_valid_1_i, wb_valid_0_i};
        t = {wb_tag_1_i, wb_tag_0_i};
        d = {wb_data_1_i, wb_data_0_i};
        for (int b = 0; b < 2; b++) begin
            if (v[b] && t[b] == tag) return {1'b1, d[b]};
        end
        return '0;
    endfunction

    function automatic ent_t fresh(input logic [PW-1:0] pl, input logic [RS-1:0] dst,
                                   input logic [1:0] v, input logic [1:0][DL-1:0] s);
        ent_t        e;
        logic [DL:0] h;
        e.busy = 1'b1;
        e.pl   = pl;
        e.dst  = dst;
        for (int k = 0; k < 2; k++) begin
            e.op[k]  = s[k];
            e.rdy[k] = v[k];
            if (!v[k]) begin
                h = snoop(s[k][RS-1:0]);
                if (h[DL]) begin
                    e.op[k]  = h[DL-1:0];
                    e.rdy[k] = 1'b1;
                end
            end
        end
        return e;
    endfunction

    // Operand as seen by readiness/issue this cycle, as {ready, value}.
    function automatic logic [DL:0] view(input int i, input int k);
        logic [DL:0] h;
        if (m[i].rdy[k]) return {1'b1, m[i].op[k]};
        if (FWD) begin
            h = snoop(m[i].op[k][RS-1:0]);
            if (h[DL]) return h;
        end
        return {1'b0, m[i].op[k]};
    endfunction

    always @(posedge clk_i) begin : model_update
        ent_t        nxt [EN];
        logic [DL:0] h;
        if (reset_i) begin
            for (int i = 0; i < EN; i++) m[i] = '0;
            model_ok = 1'b1;
        end else if (kill_i) begin
            for (int i = 0; i < EN; i++) m[i].busy = 1'b0;
        end else begin
            nxt = m;
            for (int i = 0; i < EN; i++) begin
                if (m[i].busy && !(issue_i && int'(issue_ptr_i) == i)) begin
                    for (int k = 0; k < 2; k++) begin
                        if (!m[i].rdy[k]) begin
                            h = snoop(m[i].op[k][RS-1:0]);
                            if (h[DL]) begin
                                nxt[i].op[k]  = h[DL-1:0];
                                nxt[i].rdy[k] = 1'b1;
                            end
                        end
                    end
                end
            end
            if (issue_i) nxt[int'(issue_ptr_i)].busy = 1'b0;
            if (we_1_i)
                nxt[int'(alloc_ptr_i)] = fresh(payload_1_i, rrftag_1_i,
                    {src2_valid_1_i, src1_valid_1_i}, {src2_1_i, src1_1_i});
            if (we_2_i)
                nxt[(int'(alloc_ptr_i) + 1) % EN] = fresh(payload_2_i, rrftag_2_i,
                    {src2_valid_2_i, src1_valid_2_i}, {src2_2_i, src1_2_i});
            m = nxt;
        end
    end

    always @(negedge clk_i) begin : compare
        logic [EN-1:0] eb, en, er;
        logic [DL:0]   a, b;
        int            p;
        if (model_ok) begin
            for (int i = 0; i < EN; i++) begin
                a     = view(i, 0);
                b     = view(i, 1);
                eb[i] = m[i].busy;
                er[i] = m[i].busy && a[DL] && b[DL];
            end
            en = eb;
            if (issue_i) en[int'(issue_ptr_i)] = 1'b0;
            check("model busy_vector", busy_vector_o, eb);
            check("model busy_next", busy_vector_next_o, en);
            check("model ready_vector", ready_vector_o, er);
            p = int'(issue_ptr_i);
            if (m[p].busy) begin
                a = view(p, 0);
                b = view(p, 1);
                check("model issue_payload", issue_payload_o, m[p].pl);
                check("model issue_rrftag", issue_rrftag_o, m[p].dst);
                check("model issue_src1", issue_src1_o, a[DL-1:0]);
                check("model issue_src2", issue_src2_o, b[DL-1:0]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        reset_i      = 1'b0;
        we_1_i       = 1'b0;
        we_2_i       = 1'b0;
        issue_i      = 1'b0;
        kill_i       = 1'b0;
        wb_valid_0_i = 1'b0;
        wb_valid_1_i = 1'b0;
    endtask

    task automatic disp1(input logic [ES-1:0] ptr, input logic [PW-1:0] pl, input logic [RS-1:0] tg,
                         input logic v1, input logic [DL-1:0] s1, input logic v2, input logic [DL-1:0] s2);
        alloc_ptr_i    = ptr;
        we_1_i         = 1'b1;
        payload_1_i    = pl;
        rrftag_1_i     = tg;
        src1_valid_1_i = v1;
        src1_1_i       = s1;
        src2_valid_1_i = v2;
        src2_1_i       = s2;
    endtask

    task automatic disp2(input logic [PW-1:0] pl, input logic [RS-1:0] tg,
                         input logic v1, input logic [DL-1:0] s1, input logic v2, input logic [DL-1:0] s2);
        we_2_i         = 1'b1;
        payload_2_i    = pl;
        rrftag_2_i     = tg;
        src1_valid_2_i = v1;
        src1_2_i       = s1;
        src2_valid_2_i = v2;
        src2_2_i       = s2;
    endtask

    initial begin
        idle();
        reset_i     = 1'b1;
        alloc_ptr_i = '0;
        issue_ptr_i = '0;
        wb_tag_0_i  = '0;
        wb_tag_1_i  = '0;
        wb_data_0_i = '0;
        wb_data_1_i = '0;
        disp1(2'd0, '0, '0, 1'b0, '0, 1'b0, '0);
        disp2('0, '0, 1'b0, '0, 1'b0, '0);
        we_1_i = 1'b0;
        we_2_i = 1'b0;
        tick();
        idle();
        @(negedge clk_i);
        check("reset busy", busy_vector_o, 4'b0000);
        check("reset ready", ready_vector_o, 4'b0000);

        // dual dispatch wrapping 3 -> 0
        tick();
        disp1(2'd3, 16'hA1A1, 6'h11, 1'b1, 32'h100, 1'b1, 32'h200);
        disp2(16'hB2B2, 6'h22, 1'b1, 32'h300, 1'b1, 32'h400);
        tick();
        idle();
        issue_ptr_i = 2'd3;
        @(negedge clk_i);
        check("wrap busy", busy_vector_o, 4'b1001);
        check("wrap ready", ready_vector_o, 4'b1001);
        check("wrap payload e3", issue_payload_o, 16'hA1A1);
        issue_ptr_i = 2'd0;
        #1;
        check("wrap payload e0", issue_payload_o, 16'hB2B2);
        check("wrap src2 e0", issue_src2_o, 32'h400);
        issue_i     = 1'b1;
        issue_ptr_i = 2'd3;
        #1;
        check("issue e3 busy_next", busy_vector_next_o, 4'b0001);
        tick();
        idle();
        issue_i     = 1'b1;
        issue_ptr_i = 2'd0;
        tick();
        idle();

        // wakeup of src1 tag 5 one cycle after dispatch
        disp1(2'd0, 16'hC0C0, 6'h33, 1'b0, 32'd5, 1'b1, 32'h1234);
        tick();
        idle();
        issue_ptr_i = 2'd0;
        @(negedge clk_i);
        check("wake pre busy", busy_vector_o, 4'b0001);
        check("wake pre ready", ready_vector_o, 4'b0000);
        wb_valid_0_i = 1'b1;
        wb_tag_0_i   = 6'd5;
        wb_data_0_i  = 32'hDEADBEEF;
        #1;
        check("wake same-cycle ready", ready_vector_o, FWD ? 4'b0001 : 4'b0000);
        tick();
        idle();
        @(negedge clk_i);
        check("wake ready", ready_vector_o, 4'b0001);
        check("wake src1", issue_src1_o, 32'hDEADBEEF);
        issue_i = 1'b1;
        tick();
        idle();

        // dispatch-time capture of src2 tag 7 from bus 1
        disp1(2'd1, 16'hD1D1, 6'h2A, 1'b1, 32'h11, 1'b0, 32'd7);
        wb_valid_1_i = 1'b1;
        wb_tag_1_i   = 6'd7;
        wb_data_1_i  = 32'hCAFEF00D;
        tick();
        idle();
        issue_ptr_i = 2'd1;
        @(negedge clk_i);
        check("capture ready", ready_vector_o, 4'b0010);
        check("capture src2", issue_src2_o, 32'hCAFEF00D);

        // both buses match at dispatch: bus 0 wins
        disp1(2'd2, 16'hE2E2, 6'h2B, 1'b0, 32'd9, 1'b1, 32'h22);
        wb_valid_0_i = 1'b1;
        wb_tag_0_i   = 6'd9;
        wb_data_0_i  = 32'hAAAA0000;
        wb_valid_1_i = 1'b1;
        wb_tag_1_i   = 6'd9;
        wb_data_1_i  = 32'hBBBB0000;
        tick();
        idle();
        issue_ptr_i = 2'd2;
        @(negedge clk_i);
        check("priority busy", busy_vector_o, 4'b0110);
        check("priority src1", issue_src1_o, 32'hAAAA0000);
        issue_i     = 1'b1;
        issue_ptr_i = 2'd1;
        #1;
        check("issue e1 busy_next", busy_vector_next_o, 4'b0100);
        tick();
        idle();
        issue_i     = 1'b1;
        issue_ptr_i = 2'd2;
        tick();
        idle();

        // busy 0011, issue entry 0
        disp1(2'd0, 16'h1111, 6'h01, 1'b1, 32'd1, 1'b1, 32'd2);
        disp2(16'h2222, 6'h02, 1'b1, 32'd3, 1'b1, 32'd4);
        tick();
        idle();
        @(negedge clk_i);
        check("pair busy", busy_vector_o, 4'b0011);
        issue_i     = 1'b1;
        issue_ptr_i = 2'd0;
        #1;
        check("pair busy_next", busy_vector_next_o, 4'b0010);
        tick();
        idle();
        @(negedge clk_i);
        check("pair after issue", busy_vector_o, 4'b0010);
        issue_i = 1'b1;
        tick();
        idle();
        @(negedge clk_i);
        check("issue non-busy", busy_vector_o, 4'b0010);

        // issue and dispatch to the same index: dispatch wins
        issue_i     = 1'b1;
        issue_ptr_i = 2'd1;
        disp1(2'd1, 16'hC3C3, 6'h3C, 1'b1, 32'd5, 1'b1, 32'd6);
        tick();
        idle();
        @(negedge clk_i);
        check("issue+disp busy", busy_vector_o, 4'b0010);
        check("issue+disp payload", issue_payload_o, 16'hC3C3);

        // fill all four, then kill with a concurrent dispatch
        disp1(2'd2, 16'h3333, 6'h03, 1'b1, 32'd7, 1'b0, 32'd40);
        disp2(16'h4444, 6'h04, 1'b1, 32'd8, 1'b1, 32'd9);
        tick();
        idle();
        disp1(2'd0, 16'h5555, 6'h05, 1'b1, 32'd10, 1'b1, 32'd11);
        tick();
        idle();
        @(negedge clk_i);
        check("full busy", busy_vector_o, 4'b1111);
        check("full ready", ready_vector_o, 4'b1011);
        kill_i = 1'b1;
        disp1(2'd0, 16'h6666, 6'h06, 1'b1, 32'd12, 1'b1, 32'd13);
        tick();
        idle();
        @(negedge clk_i);
        check("kill busy", busy_vector_o, 4'b0000);
        check("kill ready", ready_vector_o, 4'b0000);

        // reset while busy overrides dispatch and issue
        disp1(2'd0, 16'h7777, 6'h07, 1'b1, 32'd14, 1'b1, 32'd15);
        disp2(16'h8888, 6'h08, 1'b1, 32'd16, 1'b1, 32'd17);
        tick();
        idle();
        @(negedge clk_i);
        check("pre-reset busy", busy_vector_o, 4'b0011);
        reset_i     = 1'b1;
        issue_i     = 1'b1;
        issue_ptr_i = 2'd0;
        disp1(2'd2, 16'h9999, 6'h09, 1'b1, 32'd18, 1'b1, 32'd19);
        tick();
        idle();
        issue_ptr_i = 2'd2;
        @(negedge clk_i);
        check("post-reset busy", busy_vector_o, 4'b0000);
        check("post-reset busy_next", busy_vector_next_o, 4'b0000);
        check("post-reset ready", ready_vector_o, 4'b0000);
        check("post-reset payload", issue_payload_o, 16'h0000);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
